mem_lsu: RTL

//  RV32I memory stage, directly downstream of the EX ALU. Takes the ALU result
//  as the effective address, or as a pass-through value for non-memory ops.

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/lsu_load_align.sv | 33 +++
 rtl/mem_lsu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I load/store funct3 encodings, LSU state enum and access-size helpers
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_t;

  // funct3[1:0] gives the access size; 1x (incl. the unsupported codes) means word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a read word and sign/zero extends it
module lsu_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - RV32I memory stage: req/gnt/rvalid data port, registered write-back beat
module mem_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [RD_W-1:0] ex_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misalign
);

  lsu_state_t      state_q;
  logic            dmem_req_q, dmem_we_q;
  logic [3:0]      dmem_be_q;
  logic [XLEN-1:0] dmem_addr_q, dmem_wdata_q;
  logic [1:0]      addr_lo_q;
  logic [2:0]      funct3_q;
  logic            wb_valid_q, wb_we_q, wb_misalign_q;
  logic [RD_W-1:0] wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic [XLEN-1:0] load_val;
  logic            is_mem;
  logic            misal;

  assign is_mem = ex_is_load | ex_is_store;
  assign misal  = is_misaligned(ex_funct3, ex_result[1:0]);

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_val)
  );

  // wb_rd_q doubles as the pending destination while an access is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_be_q     <= '0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      addr_lo_q     <= '0;
      funct3_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_misalign_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
    end else begin
      wb_valid_q    <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            wb_rd_q <= ex_rd;
            if (!is_mem) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= (ex_rd != '0);
              wb_data_q  <= ex_result;
            end else if (misal) begin
              wb_valid_q    <= 1'b1;
              wb_misalign_q <= 1'b1;
              wb_data_q     <= ex_result;
            end else begin
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= ex_is_store;
              dmem_be_q    <= byte_en(ex_funct3, ex_result[1:0]);
              dmem_addr_q  <= {ex_result[XLEN-1:2], 2'b00};
              dmem_wdata_q <= store_lanes(ex_funct3, ex_store_data);
              addr_lo_q    <= ex_result[1:0];
              funct3_q     <= ex_funct3;
              state_q      <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req_q <= 1'b0;
            if (dmem_we_q) begin
              wb_valid_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            wb_valid_q <= 1'b1;
            wb_we_q    <= (wb_rd_q != '0);
            wb_data_q  <= load_val;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready    = (state_q == IDLE);
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_be     = dmem_be_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_we       = wb_we_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign wb_misalign = wb_misalign_q;

endmodule
